// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : Circular transmit byte FIFO with a dispatcher that hands
//                bytes one at a time to the UART transmit controller.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
    parameter int DEPTH       = 16,
    parameter int AW          = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [7:0]    tx_data,
    output logic          tx_en,
    input  logic          tx_rdy,
    output logic          ack_err
);

    localparam int              c_TW       = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [c_TW-1:0] c_TMO_LAST = c_TW'(ACK_TIMEOUT - 1);
    localparam logic [AW:0]     c_FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]     c_CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]   c_PTR_ONE  = AW'(1);

    localparam logic [1:0] c_ST_IDLE      = 2'd0;
    localparam logic [1:0] c_ST_WAIT_BUSY = 2'd1;
    localparam logic [1:0] c_ST_WAIT_DONE = 2'd2;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            r_full;
    logic            r_empty;
    logic            r_overflow;
    logic [7:0]      r_tx_data;
    logic            r_tx_en;
    logic            r_ack_err;
    logic [1:0]      r_state;
    logic [c_TW-1:0] r_tmo;

    logic            w_push;
    logic            w_pop;
    logic [AW:0]     w_count_nxt;

    // full is the registered flag, so a same-cycle pop never frees room for a write
    assign w_push = wr_en & ~r_full;
    assign w_pop  = (r_state == c_ST_IDLE) & ~r_empty & tx_rdy;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + c_CNT_ONE;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - c_CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_empty    <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count    <= w_count_nxt;
            r_full     <= (w_count_nxt == c_FULL_CNT);
            r_empty    <= (w_count_nxt == '0);
            r_overflow <= wr_en & r_full;
        end
    end

    // A timed-out handshake is treated as sent; the byte is not re-queued
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_tx_data <= 8'h00;
            r_tx_en   <= 1'b0;
            r_ack_err <= 1'b0;
            r_tmo     <= '0;
        end else begin
            r_tx_en   <= 1'b0;
            r_ack_err <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_tx_data <= r_mem[r_rd_ptr];
                        r_tx_en   <= 1'b1;
                        r_tmo     <= '0;
                        r_state   <= c_ST_WAIT_BUSY;
                    end
                end
                c_ST_WAIT_BUSY: begin
                    if (!tx_rdy) begin
                        r_state <= c_ST_WAIT_DONE;
                    end else if (r_tmo == c_TMO_LAST) begin
                        r_ack_err <= 1'b1;
                        r_state   <= c_ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                c_ST_WAIT_DONE: begin
                    if (tx_rdy) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign full     = r_full;
    assign empty    = r_empty;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign tx_data  = r_tx_data;
    assign tx_en    = r_tx_en;
    assign ack_err  = r_ack_err;

endmodule

`default_nettype wire
